// File: rtl/i2s_link_sequencer.sv
// Frame-level sequencer for the mono I2S link: lrclk/slot generation, bring-up FSM and DSP handshakes.
// Optional: define I2S_SEQ_HOLD_ON_UNDERRUN_EN to hold tx_sample on underrun instead of zeroing it.
module i2s_link_sequencer #(
    parameter int WORD_WIDTH     = 24,
    parameter int STARTUP_FRAMES = 4096
) (
    input  logic                  bclk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  lrclk,
    output logic [5:0]            slot_cnt,
    output logic [1:0]            state,
    input  logic [WORD_WIDTH-1:0] rx_sample,
    input  logic                  rx_valid,
    output logic [WORD_WIDTH-1:0] dsp_in_data,
    output logic                  dsp_in_valid,
    input  logic                  dsp_in_ready,
    input  logic [WORD_WIDTH-1:0] dsp_out_data,
    input  logic                  dsp_out_valid,
    output logic                  dsp_out_ready,
    output logic [WORD_WIDTH-1:0] tx_sample,
    output logic [7:0]            underrun_cnt,
    output logic [7:0]            overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [15:0] LP_LAST_WARM = 16'(STARTUP_FRAMES - 1);

    state_t                r_state;
    logic [5:0]            r_slot;
    logic [15:0]           r_warm;
    logic [WORD_WIDTH-1:0] r_in_data;
    logic                  r_in_valid;
    logic                  r_out_ready;
    logic [WORD_WIDTH-1:0] r_pending;
    logic                  r_fresh;
    logic [WORD_WIDTH-1:0] r_tx;
    logic [7:0]            r_under;
    logic [7:0]            r_over;

    logic w_boundary;
    logic w_in_accept;
    logic w_out_accept;

    assign w_boundary   = (r_slot == 6'd63) && (r_state != ST_IDLE);
    assign w_in_accept  = r_in_valid && dsp_in_ready;
    assign w_out_accept = dsp_out_valid && r_out_ready;

    // NOTE: every register here, including the data-path words, is reset so all outputs read 0 during reset.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_warm      <= '0;
            r_in_data   <= '0;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
            r_pending   <= '0;
            r_fresh     <= 1'b0;
            r_tx        <= '0;
            r_under     <= '0;
            r_over      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_slot     <= '0;
                    r_warm     <= '0;
                    r_fresh    <= 1'b0;
                    r_under    <= '0;
                    r_over     <= '0;
                    r_in_valid <= 1'b0;
                    r_tx       <= '0;
                    if (enable) begin
                        if (STARTUP_FRAMES == 0) begin
                            r_state     <= ST_RUN;
                            r_out_ready <= 1'b1;
                        end else begin
                            r_state <= ST_WARMUP;
                        end
                    end
                end

                ST_WARMUP: begin
                    r_slot <= r_slot + 6'd1;
                    if (w_boundary) begin
                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else if (r_warm == LP_LAST_WARM) begin
                            r_state     <= ST_RUN;
                            r_out_ready <= 1'b1;
                        end else begin
                            r_warm <= r_warm + 16'd1;
                        end
                    end
                end

                ST_RUN: begin
                    r_slot <= r_slot + 6'd1;

                    // A strobe with acceptance on the same cycle is a clean hand-over, not an overrun.
                    if (rx_valid) begin
                        r_in_data  <= rx_sample;
                        r_in_valid <= 1'b1;
                        if (r_in_valid && !dsp_in_ready && r_over != 8'hFF)
                            r_over <= r_over + 8'd1;
                    end else if (w_in_accept) begin
                        r_in_valid <= 1'b0;
                    end

                    if (w_out_accept)
                        r_pending <= dsp_out_data;

                    // Later assignments win, so an exit also drops any word loaded this cycle.
                    if (w_boundary && !enable) begin
                        r_state     <= ST_IDLE;
                        r_out_ready <= 1'b0;
                        r_in_valid  <= 1'b0;
                        r_tx        <= '0;
                    end else if (w_boundary) begin
                        if (r_fresh) begin
                            r_tx <= r_pending;
                        end else begin
                            if (r_under != 8'hFF)
                                r_under <= r_under + 8'd1;
`ifdef I2S_SEQ_HOLD_ON_UNDERRUN_EN
                            r_tx <= r_tx;
`else
                            r_tx <= '0;
`endif
                        end
                        r_fresh <= w_out_accept;
                    end else if (w_out_accept) begin
                        r_fresh <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_out_ready <= 1'b0;
                end
            endcase
        end
    end

    assign lrclk         = r_slot[5];
    assign slot_cnt      = r_slot;
    assign state         = r_state;
    assign dsp_in_data   = r_in_data;
    assign dsp_in_valid  = r_in_valid;
    assign dsp_out_ready = r_out_ready;
    assign tx_sample     = r_tx;
    assign underrun_cnt  = r_under;
    assign overrun_cnt   = r_over;

endmodule

// File: tb/tb_i2s_link_sequencer.sv
// Directed bench for i2s_link_sequencer with STARTUP_FRAMES = 2; honours I2S_SEQ_HOLD_ON_UNDERRUN_EN.
module tb_i2s_link_sequencer;

    logic        bclk;
    logic        rst_n;
    logic        enable;
    logic        lrclk;
    logic [5:0]  slot_cnt;
    logic [1:0]  state;
    logic [23:0] rx_sample;
    logic        rx_valid;
    logic [23:0] dsp_in_data;
    logic        dsp_in_valid;
    logic        dsp_in_ready;
    logic [23:0] dsp_out_data;
    logic        dsp_out_valid;
    logic        dsp_out_ready;
    logic [23:0] tx_sample;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef I2S_SEQ_HOLD_ON_UNDERRUN_EN
    localparam bit HOLD_MODE = 1'b1;
`else
    localparam bit HOLD_MODE = 1'b0;
`endif

    i2s_link_sequencer #(.WORD_WIDTH(24), .STARTUP_FRAMES(2)) dut (
        .bclk          (bclk),
        .rst_n         (rst_n),
        .enable        (enable),
        .lrclk         (lrclk),
        .slot_cnt      (slot_cnt),
        .state         (state),
        .rx_sample     (rx_sample),
        .rx_valid      (rx_valid),
        .dsp_in_data   (dsp_in_data),
        .dsp_in_valid  (dsp_in_valid),
        .dsp_in_ready  (dsp_in_ready),
        .dsp_out_data  (dsp_out_data),
        .dsp_out_valid (dsp_out_valid),
        .dsp_out_ready (dsp_out_ready),
        .tx_sample     (tx_sample),
        .underrun_cnt  (underrun_cnt),
        .overrun_cnt   (overrun_cnt)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic wait_slot(input logic [5:0] target);
        int n = 0;
        while (slot_cnt !== target && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (slot_cnt !== target) begin
            n_fail++;
            $display("FAIL wait_slot timeout got %0d expected %0d", slot_cnt, target);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (state !== 2'd2 && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL wait_run timeout got state %0d expected 2", state);
        end
    endtask

    task automatic boundary();
        wait_slot(6'd63);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; rx_sample = '0; rx_valid = 1'b0;
        dsp_in_ready = 1'b0; dsp_out_data = '0; dsp_out_valid = 1'b0;
        #3;
        n_checks++;
        if ({state, slot_cnt, lrclk, dsp_in_valid, dsp_out_ready, tx_sample, underrun_cnt, overrun_cnt, dsp_in_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs state=%0d slot=%0d tx=%h got nonzero expected all 0", state, slot_cnt, tx_sample);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (state !== 2'd0 || slot_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_frozen got state=%0d slot=%0d expected 0/0", state, slot_cnt);
        end
    endtask

    task automatic test_warmup();
        logic [6:0] k7;
        enable = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd1 || slot_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL warmup_entry got state=%0d slot=%0d expected 1/0", state, slot_cnt);
        end
        for (int k = 1; k < 128; k++) begin
            tick();
            k7 = 7'(k);
            n_checks++;
            if (slot_cnt !== k7[5:0] || lrclk !== k7[5] || state !== 2'd1 || tx_sample !== 24'd0 || dsp_out_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL warmup_cycle k=%0d got slot=%0d lr=%b st=%0d tx=%h expected slot=%0d lr=%b st=1 tx=0",
                         k, slot_cnt, lrclk, state, tx_sample, k7[5:0], k7[5]);
            end
        end
        tick();
        n_checks++;
        if (state !== 2'd2 || slot_cnt !== 6'd0 || lrclk !== 1'b0 || dsp_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry got state=%0d slot=%0d rdy=%b expected 2/0/1", state, slot_cnt, dsp_out_ready);
        end
    endtask

    task automatic test_passthrough();
        rx_sample = 24'h123456; rx_valid = 1'b1; dsp_in_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (dsp_in_valid !== 1'b1 || dsp_in_data !== 24'h123456) begin
            n_fail++;
            $display("FAIL rx_to_dsp got v=%b d=%h expected 1/123456", dsp_in_valid, dsp_in_data);
        end
        tick();
        n_checks++;
        if (dsp_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dsp_in_one_cycle got %b expected 0", dsp_in_valid);
        end
        dsp_in_ready = 1'b0;
        dsp_out_data = 24'h654321; dsp_out_valid = 1'b1;
        tick();
        dsp_out_valid = 1'b0;
        wait_slot(6'd63);
        n_checks++;
        if (tx_sample !== 24'd0) begin
            n_fail++;
            $display("FAIL tx_before_boundary got %h expected 000000", tx_sample);
        end
        tick();
        n_checks++;
        if (slot_cnt !== 6'd0 || tx_sample !== 24'h654321 || underrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL tx_update got slot=%0d tx=%h und=%0d expected 0/654321/0", slot_cnt, tx_sample, underrun_cnt);
        end
    endtask

    task automatic test_overrun();
        dsp_in_ready = 1'b0;
        rx_sample = 24'h000001; rx_valid = 1'b1; tick();
        rx_sample = 24'h000002; tick();
        rx_valid = 1'b0; tick();
        n_checks++;
        if (dsp_in_data !== 24'h000002 || dsp_in_valid !== 1'b1 || overrun_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL overrun got d=%h v=%b ovr=%0d expected 000002/1/1", dsp_in_data, dsp_in_valid, overrun_cnt);
        end
        dsp_in_ready = 1'b1; tick();
        n_checks++;
        if (dsp_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain got v=%b expected 0", dsp_in_valid);
        end
        dsp_in_ready = 1'b0;
        rx_sample = 24'h000003; rx_valid = 1'b1; tick();
        rx_sample = 24'h000004; dsp_in_ready = 1'b1; tick();
        rx_valid = 1'b0;
        n_checks++;
        if (dsp_in_data !== 24'h000004 || dsp_in_valid !== 1'b1 || overrun_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL accept_and_load got d=%h v=%b ovr=%0d expected 000004/1/1", dsp_in_data, dsp_in_valid, overrun_cnt);
        end
        tick();
        dsp_in_ready = 1'b0;
        n_checks++;
        if (dsp_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_drain got v=%b expected 0", dsp_in_valid);
        end
    endtask

    task automatic test_underrun();
        logic [23:0] exp_tx;
        dsp_out_data = 24'h7FFFFF; dsp_out_valid = 1'b1; tick();
        dsp_out_valid = 1'b0;
        boundary();
        n_checks++;
        if (tx_sample !== 24'h7FFFFF || underrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL underrun_setup got tx=%h und=%0d expected 7fffff/0", tx_sample, underrun_cnt);
        end
        exp_tx = HOLD_MODE ? 24'h7FFFFF : 24'h000000;
        for (int f = 1; f <= 3; f++) begin
            boundary();
            n_checks++;
            if (underrun_cnt !== 8'(f) || tx_sample !== exp_tx) begin
                n_fail++;
                $display("FAIL underrun_frame f=%0d got und=%0d tx=%h expected %0d/%h", f, underrun_cnt, tx_sample, f, exp_tx);
            end
        end
        wait_slot(6'd63);
        dsp_out_data = 24'h0ABCDE; dsp_out_valid = 1'b1;
        tick();
        dsp_out_valid = 1'b0;
        n_checks++;
        if (underrun_cnt !== 8'd4 || tx_sample !== exp_tx) begin
            n_fail++;
            $display("FAIL boundary_beat_underrun got und=%0d tx=%h expected 4/%h", underrun_cnt, tx_sample, exp_tx);
        end
        boundary();
        n_checks++;
        if (underrun_cnt !== 8'd4 || tx_sample !== 24'h0ABCDE) begin
            n_fail++;
            $display("FAIL boundary_beat_next got und=%0d tx=%h expected 4/0abcde", underrun_cnt, tx_sample);
        end
    endtask

    task automatic test_disable();
        wait_slot(6'd20); enable = 1'b0;
        wait_slot(6'd30); enable = 1'b1;
        boundary();
        n_checks++;
        if (state !== 2'd2 || slot_cnt !== 6'd0 || underrun_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL cancel_exit got state=%0d slot=%0d und=%0d expected 2/0/5", state, slot_cnt, underrun_cnt);
        end
        wait_slot(6'd10); enable = 1'b0;
        while (slot_cnt !== 6'd63 && state === 2'd2) begin
            tick();
            n_checks++;
            if (state !== 2'd2) begin
                n_fail++;
                $display("FAIL disable_hold slot=%0d got state=%0d expected 2", slot_cnt, state);
            end
        end
        tick();
        n_checks++;
        if (state !== 2'd0 || slot_cnt !== 6'd0 || lrclk !== 1'b0 || tx_sample !== 24'd0 ||
            dsp_out_ready !== 1'b0 || dsp_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_idle got state=%0d slot=%0d lr=%b tx=%h rdy=%b expected 0/0/0/000000/0",
                     state, slot_cnt, lrclk, tx_sample, dsp_out_ready);
        end
        tick(); tick();
        n_checks++;
        if (underrun_cnt !== 8'd0 || overrun_cnt !== 8'd0 || slot_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_clear got und=%0d ovr=%0d slot=%0d expected 0/0/0", underrun_cnt, overrun_cnt, slot_cnt);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        wait_run();
        wait_slot(6'd40);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, slot_cnt, lrclk, dsp_in_valid, dsp_out_ready, tx_sample, underrun_cnt, overrun_cnt, dsp_in_data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got state=%0d slot=%0d lr=%b d=%h expected all 0", state, slot_cnt, lrclk, dsp_in_data);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        wait_run();
        for (int f = 1; f <= 300; f++) begin
            boundary();
            if (f == 255 || f == 300) begin
                n_checks++;
                if (underrun_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL underrun_sat f=%0d got %0d expected 255", f, underrun_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_passthrough();
        test_overrun();
        test_underrun();
        test_disable();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
